// File: rtl/sync_ptr_cdc.sv
// Multi-channel, multi-stage synchroniser for Gray-coded FIFO pointers entering the rclk domain.
// Each channel also yields a registered binary pointer, a modulo advance delta and an advance pulse.
module sync_ptr_cdc #(
   parameter int PTR_WIDTH   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CHANNELS    = 1
) (
   input  logic                            rclk,
   input  logic                            rrst,
   input  logic [CHANNELS*PTR_WIDTH-1:0]   w_ptr_gray,
   output logic [CHANNELS*PTR_WIDTH-1:0]   rq_wptr_gray,
   output logic [CHANNELS*PTR_WIDTH-1:0]   rq_wptr_bin,
   output logic [CHANNELS*PTR_WIDTH-1:0]   rq_wptr_delta,
   output logic [CHANNELS-1:0]             rq_wptr_adv
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_ptr_cdc: SYNC_STAGES must be in 2..4");
   end
   if (PTR_WIDTH < 2 || PTR_WIDTH > 32) begin : g_bad_width
      $error("sync_ptr_cdc: PTR_WIDTH must be in 2..32");
   end
   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("sync_ptr_cdc: CHANNELS must be in 1..8");
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
      logic [PTR_WIDTH-1:0] gray_s;
      logic [PTR_WIDTH-1:0] next_bin;
      logic [PTR_WIDTH-1:0] bin_q;
      logic [PTR_WIDTH-1:0] delta_q;
      logic                 adv_q;

      // Plain flop chain: nothing may sit between stages, or metastability settling time is lost.
      always_ff @(posedge rclk or posedge rrst) begin
         if (rrst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
               sync_q[k] <= '0;
            end
         end else begin
            sync_q[0] <= w_ptr_gray[c*PTR_WIDTH +: PTR_WIDTH];
            for (int k = 1; k < SYNC_STAGES; k++) begin
               sync_q[k] <= sync_q[k-1];
            end
         end
      end

      assign gray_s = sync_q[SYNC_STAGES-1];

      // Binary bit i is the XOR of all Gray bits at or above i.
      always_comb begin
         next_bin = '0;
         for (int i = 0; i < PTR_WIDTH; i++) begin
            next_bin[i] = ^(gray_s >> i);
         end
      end

      // Unsigned subtraction drops the borrow, so wrap-around needs no special case.
      always_ff @(posedge rclk or posedge rrst) begin
         if (rrst) begin
            bin_q   <= '0;
            delta_q <= '0;
            adv_q   <= 1'b0;
         end else begin
            bin_q   <= next_bin;
            delta_q <= next_bin - bin_q;
            adv_q   <= (next_bin != bin_q);
         end
      end

      assign rq_wptr_gray[c*PTR_WIDTH +: PTR_WIDTH]  = gray_s;
      assign rq_wptr_bin[c*PTR_WIDTH +: PTR_WIDTH]   = bin_q;
      assign rq_wptr_delta[c*PTR_WIDTH +: PTR_WIDTH] = delta_q;
      assign rq_wptr_adv[c]                          = adv_q;
   end

endmodule

// File: tb/tb_sync_ptr_cdc.sv
// Scoreboard bench for sync_ptr_cdc: several parameterisations share rclk/rrst,
// expected per-edge outputs are queued when an input step is driven and popped each edge.
module tb_sync_ptr_cdc;

   typedef struct packed {
      logic [31:0] gray;
      logic [31:0] bin;
      logic [31:0] delta;
      logic [7:0]  adv;
   } exp_t;

   logic rclk = 1'b0;
   logic rrst = 1'b1;

   logic [7:0]  g_a = '0, a_gray, a_bin, a_delta;
   logic        a_adv;
   logic [3:0]  g_b = '0, b_gray, b_bin, b_delta;
   logic        b_adv;
   logic [23:0] g_c = '0, c_gray, c_bin, c_delta;
   logic [2:0]  c_adv;
   logic [7:0]  g_d = '0, d_gray, d_bin, d_delta;
   logic        d_adv;
   logic [7:0]  g_e = '0, e_gray, e_bin, e_delta;
   logic        e_adv;

   exp_t sb_q[$];
   exp_t got, want;
   int   checks = 0;
   int   errors = 0;

   always #5 rclk = ~rclk;

   sync_ptr_cdc #(.PTR_WIDTH(8), .SYNC_STAGES(2), .CHANNELS(1)) u_w8s2 (
      .rclk(rclk), .rrst(rrst), .w_ptr_gray(g_a), .rq_wptr_gray(a_gray),
      .rq_wptr_bin(a_bin), .rq_wptr_delta(a_delta), .rq_wptr_adv(a_adv));
   sync_ptr_cdc #(.PTR_WIDTH(4), .SYNC_STAGES(2), .CHANNELS(1)) u_w4 (
      .rclk(rclk), .rrst(rrst), .w_ptr_gray(g_b), .rq_wptr_gray(b_gray),
      .rq_wptr_bin(b_bin), .rq_wptr_delta(b_delta), .rq_wptr_adv(b_adv));
   sync_ptr_cdc #(.PTR_WIDTH(8), .SYNC_STAGES(2), .CHANNELS(3)) u_ch3 (
      .rclk(rclk), .rrst(rrst), .w_ptr_gray(g_c), .rq_wptr_gray(c_gray),
      .rq_wptr_bin(c_bin), .rq_wptr_delta(c_delta), .rq_wptr_adv(c_adv));
   sync_ptr_cdc #(.PTR_WIDTH(8), .SYNC_STAGES(3), .CHANNELS(1)) u_s3 (
      .rclk(rclk), .rrst(rrst), .w_ptr_gray(g_d), .rq_wptr_gray(d_gray),
      .rq_wptr_bin(d_bin), .rq_wptr_delta(d_delta), .rq_wptr_adv(d_adv));
   sync_ptr_cdc #(.PTR_WIDTH(8), .SYNC_STAGES(4), .CHANNELS(1)) u_s4 (
      .rclk(rclk), .rrst(rrst), .w_ptr_gray(g_e), .rq_wptr_gray(e_gray),
      .rq_wptr_bin(e_bin), .rq_wptr_delta(e_delta), .rq_wptr_adv(e_adv));

   function automatic logic [31:0] g2b(input logic [31:0] g, input int width);
      logic [31:0] b;
      b = '0;
      b[width-1] = g[width-1];
      for (int i = width - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic exp_t obs(input int inst);
      exp_t o;
      o = '0;
      case (inst)
         0: begin o.gray = 32'(a_gray); o.bin = 32'(a_bin); o.delta = 32'(a_delta); o.adv = 8'(a_adv); end
         1: begin o.gray = 32'(b_gray); o.bin = 32'(b_bin); o.delta = 32'(b_delta); o.adv = 8'(b_adv); end
         2: begin o.gray = 32'(c_gray); o.bin = 32'(c_bin); o.delta = 32'(c_delta); o.adv = 8'(c_adv); end
         3: begin o.gray = 32'(d_gray); o.bin = 32'(d_bin); o.delta = 32'(d_delta); o.adv = 8'(d_adv); end
         default: begin o.gray = 32'(e_gray); o.bin = 32'(e_bin); o.delta = 32'(e_delta); o.adv = 8'(e_adv); end
      endcase
      return o;
   endfunction

   // Queue the expected outputs after each of the next stages+2 edges for a step old_g -> new_g
   // on channel ch, starting from a settled state.
   task automatic push_step(input int stages, input int width, input int ch,
                            input logic [31:0] old_g, input logic [31:0] new_g);
      logic [31:0] ob, nb, mask;
      exp_t e;
      mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      ob = g2b(old_g, width);
      nb = g2b(new_g, width);
      for (int k = 1; k <= stages + 2; k++) begin
         e.gray  = (k >= stages ? new_g : old_g) << (ch * width);
         e.bin   = (k > stages ? nb : ob) << (ch * width);
         e.delta = (k == stages + 1) ? (((nb - ob) & mask) << (ch * width)) : 32'd0;
         e.adv   = (k == stages + 1 && nb != ob) ? 8'(1 << ch) : 8'd0;
         sb_q.push_back(e);
      end
   endtask

   task automatic applyStimulus(input int inst, input logic [31:0] value);
      case (inst)
         0: g_a = value[7:0];
         1: g_b = value[3:0];
         3: g_d = value[7:0];
         default: g_e = value[7:0];
      endcase
   endtask

   task automatic test_reset();
      #1;
      for (int inst = 0; inst < 5; inst++) begin
         got = obs(inst);
         checks++;
         if (got !== '0) begin
            errors++;
            $display("[TB] FAIL reset inst%0d: got %h/%h/%h/%h want all zero",
                     inst, got.gray, got.bin, got.delta, got.adv);
         end
      end
      @(negedge rclk);
      rrst = 1'b0;
   endtask

   task automatic test_latency();
      applyStimulus(0, 32'h07);
      push_step(2, 8, 0, 32'h00, 32'h07);
      for (int k = 1; sb_q.size() > 0; k++) begin
         @(posedge rclk); #1;
         got = obs(0); want = sb_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL latency edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                     k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seq [3];
      seq[0] = 32'h0; seq[1] = 32'h8; seq[2] = 32'h0;
      for (int s = 1; s < 3; s++) begin
         applyStimulus(1, seq[s]);
         push_step(2, 4, 0, seq[s-1], seq[s]);
         for (int k = 1; sb_q.size() > 0; k++) begin
            @(posedge rclk); #1;
            got = obs(1); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
               errors++;
               $display("[TB] FAIL wrap step%0d edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                        s, k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
            end
         end
      end
   endtask

   task automatic test_jump();
      logic [31:0] seq [3];
      seq[0] = 32'h0; seq[1] = 32'h2; seq[2] = 32'h5;
      for (int s = 1; s < 3; s++) begin
         applyStimulus(1, seq[s]);
         push_step(2, 4, 0, seq[s-1], seq[s]);
         for (int k = 1; sb_q.size() > 0; k++) begin
            @(posedge rclk); #1;
            got = obs(1); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
               errors++;
               $display("[TB] FAIL jump step%0d edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                        s, k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
            end
         end
      end
   endtask

   task automatic test_channels();
      g_c[15:8] = 8'h01;
      push_step(2, 8, 1, 32'h00, 32'h01);
      for (int k = 1; sb_q.size() > 0; k++) begin
         @(posedge rclk); #1;
         got = obs(2); want = sb_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL channels edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                     k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
         end
      end
   endtask

   task automatic test_stage_sweep();
      for (int inst = 3; inst <= 4; inst++) begin
         applyStimulus(inst, 32'h07);
         push_step(inst, 8, 0, 32'h00, 32'h07);
         for (int k = 1; sb_q.size() > 0; k++) begin
            @(posedge rclk); #1;
            got = obs(inst); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
               errors++;
               $display("[TB] FAIL stages%0d edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                        inst, k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      // Gray 0x0D is binary 9; first settle it from the 0x07 left by the latency scenario.
      applyStimulus(0, 32'h0D);
      push_step(2, 8, 0, 32'h07, 32'h0D);
      for (int k = 1; sb_q.size() > 0; k++) begin
         @(posedge rclk); #1;
         got = obs(0); want = sb_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL preload edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                     k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
         end
      end
      #2 rrst = 1'b1;
      #1;
      for (int inst = 0; inst < 3; inst++) begin
         got = obs(inst);
         checks++;
         if (got !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset inst%0d: got %h/%h/%h/%h want all zero",
                     inst, got.gray, got.bin, got.delta, got.adv);
         end
      end
      #2 rrst = 1'b0;
      push_step(2, 8, 0, 32'h00, 32'h0D);
      for (int k = 1; sb_q.size() > 0; k++) begin
         @(posedge rclk); #1;
         got = obs(0); want = sb_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL post_reset edge%0d: got g=%h b=%h d=%h a=%h want g=%h b=%h d=%h a=%h",
                     k, got.gray, got.bin, got.delta, got.adv, want.gray, want.bin, want.delta, want.adv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_wrap();
      test_jump();
      test_channels();
      test_stage_sweep();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_ptr_cdc.md
# sync_ptr_cdc

Parametrised multi-channel, multi-stage synchroniser for Gray-coded FIFO pointers crossing into the `rclk` domain. It generalises the fixed two-flop pointer synchroniser: stage count and channel count are configurable, and each channel also produces a registered binary pointer, a wrap-safe advance delta and an advance pulse. Downstream full/empty and occupancy logic uses these outputs directly.

## Interface
Parameters:
- `PTR_WIDTH`, default 8: width of each pointer (Gray and binary); legal 2..32.
- `SYNC_STAGES`, default 2: number of synchroniser flops per bit; legal 2..4. Any other value is a compile-time error.
- `CHANNELS`, default 1: number of independent pointers; legal 1..8.

Ports:
- `rclk`, in, 1: destination clock.
- `rrst`, in, 1: reset, asynchronous assert, active-high. Release must be synchronous to `rclk`; the integrator guarantees this.
- `w_ptr_gray`, in, `CHANNELS*PTR_WIDTH`: source Gray pointers, asynchronous to `rclk`. Channel c occupies bits `[c*PTR_WIDTH +: PTR_WIDTH]`.
- `rq_wptr_gray`, out, `CHANNELS*PTR_WIDTH`: synchronised Gray pointers.
- `rq_wptr_bin`, out, `CHANNELS*PTR_WIDTH`: binary equivalent of `rq_wptr_gray`, registered.
- `rq_wptr_delta`, out, `CHANNELS*PTR_WIDTH`: per-channel advance since the previous cycle, modulo 2^PTR_WIDTH, registered.
- `rq_wptr_adv`, out, `CHANNELS`: per-channel 1-cycle pulse, high when that channel's delta is nonzero.

## Operation
- Per channel, per bit there is a chain `s[1]..s[SYNC_STAGES]` clocked on `rclk`.
  - `s[1]` samples `w_ptr_gray`.
  - `s[k]` samples `s[k-1]`.
  - `rq_wptr_gray` is `s[SYNC_STAGES]`.
  - No logic sits between stages.
- Gray-to-binary: `b[PTR_WIDTH-1] = g[PTR_WIDTH-1]`, and `b[i] = b[i+1] ^ g[i]`. It is computed combinationally from `s[SYNC_STAGES]`.
- Each rising `rclk` edge, per channel, with `nb` = the converted value and `bin_q` = the current `rq_wptr_bin`:
  - `rq_wptr_bin` <= `nb`.
  - `rq_wptr_delta` <= `(nb - bin_q) mod 2^PTR_WIDTH`, as unsigned PTR_WIDTH-bit subtraction with the borrow discarded.
  - `rq_wptr_adv` <= `(nb != bin_q)`.
- Wrap-around: the pointer going from `2^PTR_WIDTH-1` to 0 yields delta 1. Modulo arithmetic handles this; there is no special case.
- Multi-step jumps (source faster than `rclk`): delta reports the full step count. Valid while the true advance between consecutive samples is < 2^PTR_WIDTH.
- A backward move is reported as a large modulo delta. No error flag is raised; detecting it is the consumer's responsibility.
- Channels are fully independent. There are no shared registers.
- Reset (`rrst`=1, asynchronous): all `s[k]`, `rq_wptr_gray`, `rq_wptr_bin`, `rq_wptr_delta` and `rq_wptr_adv` clear to 0 immediately, without waiting for a clock edge.
- Reset mid-operation: in-flight samples are discarded.
  - After release, the baseline is 0.
  - A nonzero input held across reset therefore produces one `adv` pulse whose delta equals the full binary value.

## Timing
- Gray latency: a change on `w_ptr_gray` that meets setup before edge E appears on `rq_wptr_gray` after edge E+SYNC_STAGES-1.
- Binary, delta and adv latency: one edge later than Gray, i.e. after edge E+SYNC_STAGES.
- `rq_wptr_adv` stays high for exactly one cycle per observed change, unless the source changes again on the next sample. In that case it stays high, with delta updated each cycle.
- Input meeting setup: no multi-bit skew, because the input is Gray.
- Input violating setup: the new value may appear one edge later; the old or new value per bit is acceptable.
- All outputs are flop outputs. There is no combinational path from any input to any output.
- Throughput: one sample per `rclk` cycle per channel.

## Test plan
1. **Latency.** `PTR_WIDTH`=8, `SYNC_STAGES`=2. Drive `w_ptr_gray`=0x07 (binary 5) before edge 1.
   - `rq_wptr_gray`=0x07 after edge 2.
   - After edge 3: `rq_wptr_bin`=5, `rq_wptr_delta`=5, `rq_wptr_adv`=1.
   - After edge 4: `adv`=0, `delta`=0.
2. **Wrap.** `PTR_WIDTH`=4. Step the Gray input 0x8 (binary 15) -> 0x0 (binary 0).
   - Cycle after the wrap propagates: `bin`=0, `delta`=1, `adv`=1.
3. **Multi-step jump.** `PTR_WIDTH`=4. Gray 0x2 (binary 3) -> 0x5 (binary 6) between samples -> `delta`=3, `adv`=1 for one cycle.
4. **Channel independence.** `CHANNELS`=3. Change only channel 1 from binary 0 to 1 (Gray 0x01).
   - Only `rq_wptr_adv[1]` pulses; channel 1 `delta`=1.
   - Channels 0 and 2: outputs stay 0.
5. **Reset.** Assert `rrst` mid-stream with input binary 9 held, between clock edges.
   - All outputs are 0 before the next edge.
   - After release plus SYNC_STAGES+1 edges: `bin`=9, `delta`=9, `adv`=1 for one cycle.
6. **Stage sweep.** Repeat scenario 1 with `SYNC_STAGES`=3 and 4. Gray latency is 3 and 4 edges; binary latency is 4 and 5 edges.
